// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: address/data/enable widths, access
// size encoding, FSM states and small per-access helpers.
package data;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int EN_W   = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [EN_W-1:0]   en_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Reserved encoding 2'b11 is treated as a word everywhere.
    function automatic en_t size_wen(input size_t size);
        case (size)
            SIZE_B:  size_wen = 4'b0001;
            SIZE_H:  size_wen = 4'b0011;
            default: size_wen = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input size_t size, input logic [1:0] lsb);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = lsb[0];
            default: misaligned = (lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Combinational selection and sign/zero extension of RAM read data
// according to the access size of the pending load.
module lsu_extract
    import data::*;
(
    input  data_t rdata,
    input  size_t size,
    input  logic  is_unsigned,
    output data_t ext
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = rdata[7:0];
    assign half_s = rdata[15:0];

    always_comb begin
        ext = rdata;
        case (size)
            SIZE_B:  ext = is_unsigned ? {24'd0, rdata[7:0]}  : data_t'(32'(byte_s));
            SIZE_H:  ext = is_unsigned ? {16'd0, rdata[15:0]} : data_t'(32'(half_s));
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, one-cycle response latency, full
// throughput when the consumer is ready. Define LSU_MISALIGN_TRAP_EN to turn
// misaligned half/word accesses into error responses instead of RAM accesses.
module lsu
    import data::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_we,
    input  size_t req_size,
    input  logic  req_unsigned,
    input  addr_t req_addr,
    input  data_t req_wdata,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output data_t rsp_rdata,
    output logic  rsp_err,
    output en_t   ram_wen,
    output addr_t ram_addr,
    output data_t ram_wdata,
    input  data_t ram_rdata
);

    state_t state, state_nxt;
    logic   accept;
    logic   mis;

    addr_t  addr_p1;
    size_t  size_p1;
    logic   uns_p1;
    logic   we_p1;
    logic   err_p1;
    data_t  ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis     = misaligned(req_size, req_addr[1:0]);
    assign rsp_err = rsp_valid & err_p1;
`else
    assign mis     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Gating with rst keeps any store from reaching the RAM while reset is held.
    assign req_ready = ~rst & ((state == IDLE) | rsp_ready);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = accept ? RESP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: request fields held for the response cycle ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1 <= '0;
            size_p1 <= SIZE_B;
            uns_p1  <= 1'b0;
            we_p1   <= 1'b0;
            err_p1  <= 1'b0;
        end else if (accept) begin
            addr_p1 <= req_addr;
            size_p1 <= req_size;
            uns_p1  <= req_unsigned;
            we_p1   <= req_we;
            err_p1  <= mis;
        end
    end

    // Holding the address outside accepts keeps ram_rdata stable during stalls.
    assign ram_addr  = accept ? req_addr : addr_p1;
    assign ram_wen   = (accept & req_we & ~mis) ? size_wen(req_size) : '0;
    assign ram_wdata = req_wdata;

    lsu_extract u_extract (
        .rdata       (ram_rdata),
        .size        (size_p1),
        .is_unsigned (uns_p1),
        .ext         (ext)
    );

    assign rsp_rdata = (rsp_valid & ~we_p1 & ~err_p1) ? ext : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with a byte-addressed RAM model whose read data
// is registered one cycle after ram_addr.
module tb_lsu;
    import data::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  req_valid = 1'b0;
    logic  req_ready;
    logic  req_we = 1'b0;
    size_t req_size = SIZE_W;
    logic  req_unsigned = 1'b0;
    addr_t req_addr = '0;
    data_t req_wdata = '0;
    logic  rsp_valid;
    logic  rsp_ready = 1'b1;
    data_t rsp_rdata;
    logic  rsp_err;
    en_t   ram_wen;
    addr_t ram_addr;
    data_t ram_wdata;
    data_t ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:63];

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: reset fills byte i with value i; bytes offset from ram_addr.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
            ram_rdata <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (ram_wen[i]) mem[6'(ram_addr[5:0] + 6'(i))] <= ram_wdata[8*i +: 8];
            ram_rdata <= {mem[6'(ram_addr[5:0] + 6'd3)], mem[6'(ram_addr[5:0] + 6'd2)],
                          mem[6'(ram_addr[5:0] + 6'd1)], mem[ram_addr[5:0]]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic we, input size_t sz, input logic uns,
                         input addr_t a, input data_t wd);
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        #1;
    endtask

    logic [31:0] exp_q;

    initial begin
        // Reset state
        step();
        step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_ram_wen",   32'(ram_wen),   32'd0);
        check("rst_ram_addr",  ram_addr,       32'd0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Store W then load W
        drive(1, 1, SIZE_W, 0, 32'h10, 32'hDEADBEEF);
        check("stw_wen",  32'(ram_wen), 32'h0000000F);
        check("stw_addr", ram_addr,     32'h10);
        check("stw_wdata", ram_wdata,   32'hDEADBEEF);
        step();
        drive(1, 0, SIZE_W, 0, 32'h10, 32'h0);
        check("stw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("stw_rsp_rdata", rsp_rdata,      32'd0);
        check("ldw_wen",       32'(ram_wen),   32'd0);
        step();
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        check("ldw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ldw_rdata",     rsp_rdata,      32'hDEADBEEF);
        step();
        check("ldw_done_valid", 32'(rsp_valid), 32'd0);
        check("ldw_done_rdata", rsp_rdata,      32'd0);

        // Store B then load B signed / unsigned
        drive(1, 1, SIZE_B, 0, 32'h21, 32'h00000080);
        check("stb_wen", 32'(ram_wen), 32'h1);
        step();
        drive(1, 0, SIZE_B, 0, 32'h21, 32'h0);
        step();
        drive(1, 0, SIZE_B, 1, 32'h21, 32'h0);
        check("ldb_signed", rsp_rdata, 32'hFFFFFF80);
        step();
        drive(1, 0, SIZE_H, 1, 32'h20, 32'h0);
        check("ldb_unsigned", rsp_rdata, 32'h00000080);
        step();
        drive(1, 0, size_t'(2'b11), 0, 32'h04, 32'h0);
        check("ldh_unsigned", rsp_rdata, 32'h00008020);
        step();
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        check("ld_rsv_size", rsp_rdata, 32'h07060504);
        step();

        // Load H signed with rsp_ready low for 3 cycles while a store is offered
        drive(1, 0, SIZE_H, 0, 32'h20, 32'h0);
        step();
        rsp_ready = 1'b0;
        drive(1, 1, SIZE_W, 0, 32'h0, 32'h11111111);
        for (int c = 0; c < 3; c++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata",     rsp_rdata,      32'hFFFF8020);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_wen",       32'(ram_wen),   32'd0);
            check("stall_addr",      ram_addr,       32'h20);
            step();
        end
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        rsp_ready = 1'b1;
        check("stall_release_rdata", rsp_rdata, 32'hFFFF8020);
        step();
        check("stall_done_valid", 32'(rsp_valid), 32'd0);

        // Four back-to-back word loads
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, SIZE_W, 1, addr_t'(4 * k), 32'h0);
            if (k > 0) begin
                check("b2b_valid", 32'(rsp_valid), 32'd1);
                check("b2b_rdata", rsp_rdata, exp_q);
            end
            exp_q = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            step();
        end
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        check("b2b_valid_last", 32'(rsp_valid), 32'd1);
        check("b2b_rdata_last", rsp_rdata, exp_q);
        step();

        // Misaligned word store @0x13
        drive(1, 1, SIZE_W, 0, 32'h13, 32'hA1B2C3D4);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_wen", 32'(ram_wen), 32'd0);
        step();
        drive(1, 0, SIZE_B, 1, 32'h13, 32'h0);
        check("mis_err",   32'(rsp_err), 32'd1);
        check("mis_rdata", rsp_rdata,    32'd0);
        step();
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        check("mis_mem_err",   32'(rsp_err), 32'd0);
        check("mis_mem_byte",  rsp_rdata,    32'h000000DE);
        step();
`else
        check("mis_wen", 32'(ram_wen), 32'hF);
        step();
        drive(1, 0, SIZE_W, 0, 32'h13, 32'h0);
        check("mis_err", 32'(rsp_err), 32'd0);
        step();
        drive(0, 0, SIZE_W, 0, 32'h0, 32'h0);
        check("mis_mem_word", rsp_rdata, 32'hA1B2C3D4);
        step();
`endif

        // Reset during RESP
        drive(1, 0, SIZE_W, 0, 32'h0, 32'h0);
        step();
        rsp_ready = 1'b0;
        drive(1, 1, SIZE_W, 0, 32'h8, 32'h55555555);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_wen",   32'(ram_wen),   32'd0);
        step();
        check("in_rst_wen", 32'(ram_wen), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Module SHALL have no parameters; widths SHALL come from data::addr_t (ADDR), data::data_t (32 bits) and data::en_t (4 bits).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  request accepted when high together with req_valid.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  size_t (2)  access size: SIZE_B, SIZE_H, SIZE_W.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  addr_t  byte address.
REQ-010 req_wdata  input  data_t  store data, right-justified.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  output  data_t  extended load data; 0 for stores.
REQ-014 rsp_err  output  1  misaligned-access error flag.
REQ-015 ram_wen  output  en_t  byte write enables to the RAM.
REQ-016 ram_addr  output  addr_t  RAM byte address.
REQ-017 ram_wdata  output  data_t  RAM write data.
REQ-018 ram_rdata  input  data_t  RAM read data, registered one cycle after ram_addr.

Function
REQ-019 FSM SHALL have states IDLE and RESP; IDLE -> RESP on accept; RESP -> IDLE on rsp_ready without a new accept; RESP -> RESP on rsp_ready with a new accept.
REQ-020 req_ready SHALL be 1 in IDLE, and equal rsp_ready in RESP.
REQ-021 On the accept cycle N, ram_addr SHALL equal req_addr combinationally; rsp_valid SHALL be 1 from cycle N+1 until consumed (one-cycle latency, one transfer per cycle sustained).
REQ-022 Outside an accept cycle, ram_addr SHALL hold the last accepted address and ram_wen SHALL be 0, so ram_rdata stays stable while rsp_ready is low.
REQ-023 Store wen: SIZE_B 4'b0001, SIZE_H 4'b0011, SIZE_W 4'b1111, asserted only on the accept cycle; ram_wen SHALL be 0 for loads.
REQ-024 ram_wdata SHALL equal req_wdata; the RAM offsets each byte from ram_addr, so no lane shifting is applied.
REQ-025 Load data: SIZE_B uses ram_rdata[7:0], SIZE_H uses [15:0], SIZE_W uses [31:0]; sign- or zero-extended per the registered req_unsigned.
REQ-026 Reserved size 2'b11 SHALL behave as SIZE_W.
REQ-027 rsp_rdata SHALL be 0 and rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-028 Simultaneous rsp consume and new accept SHALL present the new response in the next cycle with no bubble.

Reset
REQ-029 On rst: state IDLE, rsp_valid 0, rsp_err 0, ram_wen 0, held address/size/unsigned/we registers 0.
REQ-030 rst during RESP SHALL drop the pending response; no store SHALL be issued after rst asserts.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN: when defined, SIZE_H with addr[0]=1 or SIZE_W with addr[1:0]!=0 SHALL drive ram_wen 0 and respond next cycle with rsp_err=1, rsp_rdata=0.
REQ-032 When LSU_MISALIGN_TRAP_EN is undefined, rsp_err SHALL be tied 0 and misaligned accesses SHALL pass to the RAM unchanged.

Structure
REQ-033 size_t enum (SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10) and en_t SHALL live in the data package.
REQ-034 Sub-module lsu_extract (combinational size/sign extension of read data) SHALL be instantiated once; the FSM stays in lsu.

Verification
REQ-035 Store W 0xDEADBEEF @0x10, then load W @0x10 -> ram_wen 4'b1111 on accept; rsp_rdata 0xDEADBEEF at N+1.
REQ-036 Store B 0x80 @0x21, then load B signed @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-037 Load H @0x20 with rsp_ready low for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready 0, ram_wen 0 throughout.
REQ-038 Back-to-back 4 loads with rsp_ready=1 -> 4 responses on 4 consecutive cycles, in order.
REQ-039 With LSU_MISALIGN_TRAP_EN defined, store W @0x13 -> ram_wen 0, rsp_err 1; memory unchanged; undefined -> bytes 0x13..0x16 written.
REQ-040 rst asserted while in RESP -> rsp_valid 0 asynchronously, req_ready 1 after release.
